// File: rtl/seg_scan_ctrl_if.sv
// Bundle between the arithmetic datapath and the seven-segment scan controller.
// The master drives the load channel. The slave drives the display pins and the status pulses.
interface seg_scan_ctrl_if;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [3:0]  en_in;
  logic        load;
  logic        load_ack;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        frame_tick;

  modport master (
    output data_in, dp_in, en_in, load,
    input  load_ack, seg, dp, an, digit_idx, frame_tick
  );

  modport slave (
    input  data_in, dp_in, en_in, load,
    output load_ack, seg, dp, an, digit_idx, frame_tick
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode scan controller with double-buffered hex/dp/enable registers.
// Define SEG_SCAN_BLANK_EN to blank the first BLANK_CYCLES cycles of every digit slot.
module seg_scan_ctrl #(
  parameter int PRESCALE     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic           clkin,
  input  logic           greset,
  seg_scan_ctrl_if.slave bus
);
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);

  typedef enum logic {S_BLANK = 1'b0, S_DRIVE = 1'b1} state_t;

`ifdef SEG_SCAN_BLANK_EN
  localparam state_t RST_STATE = (BLANK_CYCLES > 0) ? S_BLANK : S_DRIVE;
`else
  localparam state_t RST_STATE = S_DRIVE;
`endif

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [1:0]    r_idx;
  logic [1:0]    w_idx_nxt;
  logic          w_frame_end;
  logic          w_xfer;
  logic [15:0]   r_stg_data;
  logic [3:0]    r_stg_dp;
  logic [3:0]    r_stg_en;
  logic          r_pending;
  logic [15:0]   r_act_data;
  logic [3:0]    r_act_dp;
  logic [3:0]    r_act_en;
  logic [15:0]   w_act_data_nxt;
  logic [3:0]    w_act_dp_nxt;
  logic [3:0]    w_act_en_nxt;
  logic [3:0]    w_nibble;
  logic [6:0]    w_seg_nxt;
  logic          w_dp_nxt;
  logic [3:0]    w_an_nxt;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic [3:0]    r_an;
  logic          r_frame_tick;
  logic          r_load_ack;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] segs;
    case (nib)
      4'h0:    segs = 7'b1000000;
      4'h1:    segs = 7'b1111001;
      4'h2:    segs = 7'b0100100;
      4'h3:    segs = 7'b0110000;
      4'h4:    segs = 7'b0011001;
      4'h5:    segs = 7'b0010010;
      4'h6:    segs = 7'b0000010;
      4'h7:    segs = 7'b1111000;
      4'h8:    segs = 7'b0000000;
      4'h9:    segs = 7'b0010000;
      4'hA:    segs = 7'b0001000;
      4'hB:    segs = 7'b0000011;
      4'hC:    segs = 7'b1000110;
      4'hD:    segs = 7'b0100001;
      4'hE:    segs = 7'b0000110;
      4'hF:    segs = 7'b0001110;
      default: segs = 7'b1111111;
    endcase
    return segs;
  endfunction

  // Slot/digit sequencing; the active set only swaps at the frame boundary.
  always_comb begin
    w_frame_end = (r_idx == 2'd3) && (r_cnt == CNT_MAX);
    w_xfer      = w_frame_end && r_pending;
    if (r_cnt == CNT_MAX) begin
      w_cnt_nxt = '0;
      w_idx_nxt = r_idx + 2'd1;
    end else begin
      w_cnt_nxt = r_cnt + CW'(1);
      w_idx_nxt = r_idx;
    end
    if (w_xfer) begin
      w_act_data_nxt = r_stg_data;
      w_act_dp_nxt   = r_stg_dp;
      w_act_en_nxt   = r_stg_en;
    end else begin
      w_act_data_nxt = r_act_data;
      w_act_dp_nxt   = r_act_dp;
      w_act_en_nxt   = r_act_en;
    end
  end

  // Pins are derived from next-state values so they change on the same edge as cnt/digit_idx.
  always_comb begin
    w_state_nxt = S_DRIVE;
    w_an_nxt    = 4'b1111;
    w_seg_nxt   = 7'b1111111;
    w_dp_nxt    = 1'b1;
    w_nibble    = w_act_data_nxt[{w_idx_nxt, 2'b00} +: 4];
`ifdef SEG_SCAN_BLANK_EN
    case (r_state)
      S_BLANK: begin
        if (int'(w_cnt_nxt) >= BLANK_CYCLES) w_state_nxt = S_DRIVE;
        else                                 w_state_nxt = S_BLANK;
      end
      S_DRIVE: begin
        if ((w_cnt_nxt == '0) && (BLANK_CYCLES > 0)) w_state_nxt = S_BLANK;
        else                                         w_state_nxt = S_DRIVE;
      end
      default: w_state_nxt = RST_STATE;
    endcase
`else
    case (r_state)
      S_BLANK: w_state_nxt = S_DRIVE;
      default: w_state_nxt = S_DRIVE;
    endcase
`endif
    case (w_state_nxt)
      S_DRIVE: begin
        if (w_act_en_nxt[w_idx_nxt]) begin
          w_an_nxt  = ~(4'b0001 << w_idx_nxt);
          w_seg_nxt = hex_decode(w_nibble);
          w_dp_nxt  = ~w_act_dp_nxt[w_idx_nxt];
        end else begin
          w_an_nxt  = 4'b1111;
          w_seg_nxt = 7'b1111111;
          w_dp_nxt  = 1'b1;
        end
      end
      default: begin
        w_an_nxt  = 4'b1111;
        w_seg_nxt = 7'b1111111;
        w_dp_nxt  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clkin or posedge greset) begin
    if (greset) begin
      r_state <= RST_STATE;
      r_cnt   <= '0;
      r_idx   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // A load on the boundary edge re-arms pending for the next frame.
  always_ff @(posedge clkin or posedge greset) begin
    if (greset) begin
      r_stg_data <= 16'h0000;
      r_stg_dp   <= 4'b0000;
      r_stg_en   <= 4'b0000;
      r_pending  <= 1'b0;
      r_act_data <= 16'h0000;
      r_act_dp   <= 4'b0000;
      r_act_en   <= 4'b0000;
    end else begin
      if (bus.load) begin
        r_stg_data <= bus.data_in;
        r_stg_dp   <= bus.dp_in;
        r_stg_en   <= bus.en_in;
      end
      if (w_frame_end) r_pending <= bus.load;
      else if (bus.load) r_pending <= 1'b1;
      r_act_data <= w_act_data_nxt;
      r_act_dp   <= w_act_dp_nxt;
      r_act_en   <= w_act_en_nxt;
    end
  end

  always_ff @(posedge clkin or posedge greset) begin
    if (greset) begin
      r_an         <= 4'b1111;
      r_seg        <= 7'b1111111;
      r_dp         <= 1'b1;
      r_frame_tick <= 1'b0;
      r_load_ack   <= 1'b0;
    end else begin
      r_an         <= w_an_nxt;
      r_seg        <= w_seg_nxt;
      r_dp         <= w_dp_nxt;
      r_frame_tick <= w_frame_end;
      r_load_ack   <= w_xfer;
    end
  end

  assign bus.an         = r_an;
  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.digit_idx  = r_idx;
  assign bus.frame_tick = r_frame_tick;
  assign bus.load_ack   = r_load_ack;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a cycle model queues the expected pins each cycle.
// Blanking expectations follow SEG_SCAN_BLANK_EN.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;
  localparam int P     = 8;
  localparam int BC    = 2;
  localparam int FRAME = 4 * P;
`ifdef SEG_SCAN_BLANK_EN
  localparam int BLANK = BC;
`else
  localparam int BLANK = 0;
`endif
  localparam logic [15:0] DARK = {1'b0, 1'b0, 2'd0, 4'b1111, 1'b1, 7'b1111111};

  logic clkin = 1'b0;
  logic greset;
  seg_scan_ctrl_if bus();

  seg_scan_ctrl #(.PRESCALE(P), .BLANK_CYCLES(BC)) dut (
    .clkin  (clkin),
    .greset (greset),
    .bus    (bus)
  );

  always #5 clkin = ~clkin;

  logic [6:0]  seg_tab [16];
  logic [15:0] exp_q [$];
  int          n_vec = 0;
  int          n_err = 0;
  int          ack_seen;
  int          tick_seen;
  logic [3:0]  an_low_seen;

  int          m_t;
  logic        m_pend;
  logic [15:0] m_stg_d, m_act_d;
  logic [3:0]  m_stg_dp, m_act_dp, m_stg_en, m_act_en;

  task automatic model_reset();
    m_t = 0; m_pend = 1'b0;
    m_stg_d = 16'h0; m_act_d = 16'h0;
    m_stg_dp = 4'h0; m_act_dp = 4'h0;
    m_stg_en = 4'h0; m_act_en = 4'h0;
    exp_q.delete();
  endtask

  // Predict one clock edge, queue the expectation, then compare after the edge.
  task automatic step(input string name);
    logic        boundary, ack;
    int          slot, c;
    logic [3:0]  an_e;
    logic [6:0]  seg_e;
    logic        dp_e;
    logic [15:0] got, exp_v;
    boundary = (m_t == FRAME - 1);
    ack      = boundary && m_pend;
    if (ack) begin
      m_act_d = m_stg_d; m_act_dp = m_stg_dp; m_act_en = m_stg_en;
    end
    if (boundary) m_pend = bus.load;
    else          m_pend = m_pend | bus.load;
    if (bus.load) begin
      m_stg_d = bus.data_in; m_stg_dp = bus.dp_in; m_stg_en = bus.en_in;
    end
    m_t  = (m_t + 1) % FRAME;
    slot = m_t / P;
    c    = m_t % P;
    an_e = 4'b1111; seg_e = 7'b1111111; dp_e = 1'b1;
    if (c >= BLANK && m_act_en[slot]) begin
      an_e  = ~(4'b0001 << slot);
      seg_e = seg_tab[m_act_d[slot*4 +: 4]];
      dp_e  = ~m_act_dp[slot];
    end
    exp_q.push_back({ack, (m_t == 0), 2'(slot), an_e, dp_e, seg_e});
    @(posedge clkin);
    #1;
    got   = {bus.load_ack, bus.frame_tick, bus.digit_idx, bus.an, bus.dp, bus.seg};
    exp_v = exp_q.pop_front();
    n_vec++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL %s t=%0d got=%h expected=%h", name, m_t, got, exp_v);
    end
    ack_seen    += int'(got[15]);
    tick_seen   += int'(got[14]);
    an_low_seen |= ~bus.an;
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] en,
                         input string name);
    bus.data_in = d; bus.dp_in = dpv; bus.en_in = en; bus.load = 1'b1;
    step(name);
    bus.load = 1'b0;
  endtask

  task automatic run_to(input int target, input string name);
    for (int i = 0; i <= FRAME && m_t != target; i++) step(name);
    if (m_t != target) begin
      n_err++;
      $display("FAIL %s_timeout t=%0d target=%0d", name, m_t, target);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp_v);
    n_vec++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp_v);
    end
  endtask

  task automatic test_reset();
    logic [15:0] got;
    greset = 1'b1; bus.load = 1'b0;
    bus.data_in = 16'h0; bus.dp_in = 4'h0; bus.en_in = 4'h0;
    model_reset();
    #12;
    got = {bus.load_ack, bus.frame_tick, bus.digit_idx, bus.an, bus.dp, bus.seg};
    n_vec++;
    if (got !== DARK) begin
      n_err++;
      $display("FAIL reset got=%h expected=%h", got, DARK);
    end
    @(negedge clkin);
    greset = 1'b0;
  endtask

  task automatic test_idle();
    tick_seen = 0; ack_seen = 0;
    repeat (3 * FRAME) step("idle");
    check_int("idle_ticks", tick_seen, 3);
    check_int("idle_acks", ack_seen, 0);
  endtask

  task automatic test_load_basic();
    ack_seen = 0;
    do_load(16'h3A0F, 4'b0100, 4'b1111, "load_basic");
    run_to(0, "load_basic");
    check_int("load_basic_ack", ack_seen, 1);
    run_to(1, "load_basic");
    check_int("slot0_an_blank", int'(bus.an), (1 < BLANK) ? 15 : 14);
    run_to(5, "load_basic");
    check_int("slot0_seg", int'(bus.seg), int'(7'b0001110));
    run_to(2 * P + 5, "load_basic");
    check_int("slot2_seg", int'(bus.seg), int'(7'b0001000));
    check_int("slot2_dp", int'(bus.dp), 0);
    run_to(3 * P + 5, "load_basic");
    check_int("slot3_seg", int'(bus.seg), int'(7'b0110000));
  endtask

  task automatic test_latest_wins();
    run_to(1, "latest_wins");
    ack_seen = 0;
    do_load(16'h1111, 4'b0000, 4'b1111, "latest_wins");
    repeat (3) step("latest_wins");
    do_load(16'h2222, 4'b0000, 4'b1111, "latest_wins");
    repeat (2 * FRAME) step("latest_wins");
    check_int("latest_wins_acks", ack_seen, 1);
    run_to(P - 1, "latest_wins");
    check_int("latest_wins_seg", int'(bus.seg), int'(7'b0100100));
    check_int("latest_wins_an", int'(bus.an), int'(4'b1110));
  endtask

  task automatic test_enable_mask();
    do_load(16'h1234, 4'b1111, 4'b0101, "enable_mask");
    run_to(0, "enable_mask");
    an_low_seen = 4'b0000;
    repeat (2 * FRAME) step("enable_mask");
    check_int("enable_mask_an", int'(an_low_seen), int'(4'b0101));
  endtask

  task automatic test_boundary_load();
    run_to(FRAME - 1, "boundary");
    ack_seen = 0;
    do_load(16'hBEEF, 4'b1001, 4'b1111, "boundary");
    check_int("boundary_no_ack", ack_seen, 0);
    repeat (FRAME) step("boundary");
    check_int("boundary_next_ack", ack_seen, 1);
    run_to(3, "boundary_pend");
    do_load(16'hC0DE, 4'b0000, 4'b1111, "boundary_pend");
    run_to(FRAME - 1, "boundary_pend");
    ack_seen = 0;
    do_load(16'h5A5A, 4'b0011, 4'b1110, "boundary_pend");
    check_int("boundary_pend_ack", ack_seen, 1);
    repeat (FRAME) step("boundary_pend");
    check_int("boundary_pend_ack2", ack_seen, 2);
  endtask

  task automatic test_reset_midframe();
    logic [15:0] got;
    run_to(2 * P + 3, "reset_mid");
    do_load(16'h9999, 4'b1111, 4'b1111, "reset_mid");
    step("reset_mid");
    #2;
    greset = 1'b1;
    #1;
    got = {bus.load_ack, bus.frame_tick, bus.digit_idx, bus.an, bus.dp, bus.seg};
    n_vec++;
    if (got !== DARK) begin
      n_err++;
      $display("FAIL reset_mid_dark got=%h expected=%h", got, DARK);
    end
    model_reset();
    @(negedge clkin);
    @(negedge clkin);
    greset = 1'b0;
    ack_seen = 0;
    an_low_seen = 4'b0000;
    repeat (2 * FRAME) step("reset_mid");
    check_int("reset_mid_acks", ack_seen, 0);
    check_int("reset_mid_an", int'(an_low_seen), 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      do_load(16'($urandom), 4'($urandom), 4'($urandom), "back_to_back");
    end
    do_load(16'h8888, 4'b0000, 4'b1111, "back_to_back");
    repeat (2 * FRAME) step("back_to_back");
  endtask

  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    test_reset();
    test_idle();
    test_load_basic();
    test_latest_wins();
    test_enable_mask();
    test_boundary_load();
    test_reset_midframe();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
